// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader FSM state encoding, the NOP instruction returned for
// unmapped fetches, and the width of the core trap-cause code.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int CAUSE_W = 3;

endpackage

// File: rtl/imem_loader_ram.sv
// Instruction store for the loader: DEPTH_WORDS x 32 bits.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write word index
//   wdata  - write data
//   raddr  - asynchronous read word index
//   rdata  - asynchronous read data
// Contents are not reset; the loader hides stale words by range gating.
module imem_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Program loader and instruction memory front-end for a small core.
// A host streams an image into the store while the core is held in reset;
// the core is then released and fetches from the store. A core trap either
// freezes the core (HALT_ON_TRAP=1) or is counted (HALT_ON_TRAP=0).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   restart                  - return to program load from any state
//   load_valid/data/last     - host image stream, load_ready handshake
//   pc / instr               - core fetch address / returned instruction
//   core_rst                 - registered reset to the core
//   trap, trap_cause         - core trap report
//   halted                   - high while frozen after a trap
//   fault_pc, fault_cause    - pc/cause of the first trap
//   trap_count               - saturating count of traps taken in RUN
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS  = 256,
    parameter bit HALT_ON_TRAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    input  logic               load_valid,
    input  logic [31:0]        load_data,
    input  logic               load_last,
    output logic               load_ready,
    input  logic [31:0]        pc,
    output logic [31:0]        instr,
    output logic               core_rst,
    input  logic               trap,
    input  logic [CAUSE_W-1:0] trap_cause,
    output logic               halted,
    output logic [31:0]        fault_pc,
    output logic [CAUSE_W-1:0] fault_cause,
    output logic [7:0]         trap_count
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // One extra bit so a completely full image (DEPTH_WORDS) is representable.
    localparam int CW = AW + 1;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] word_count;
    logic          accept;
    logic          last_word;
    logic          trap_taken;
    logic [31:0]   rdata;
    logic [31:0]   idx_ext;
    logic          in_range;

    // A word presented together with restart is dropped.
    assign accept     = (state == S_LOAD) && load_valid && !restart;
    assign last_word  = load_last || (wr_ptr == AW'(DEPTH_WORDS - 1));
    assign trap_taken = (state == S_RUN) && trap && !restart;

    imem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (accept && !rst),
        .waddr (wr_ptr),
        .wdata (load_data),
        .raddr (pc[AW+1:2]),
        .rdata (rdata)
    );

    // Compare the full word index so high pc bits never alias onto the store.
    assign idx_ext  = {2'b00, pc[31:2]};
    assign in_range = (pc[1:0] == 2'b00) && (idx_ext < 32'(word_count));
    assign instr    = in_range ? rdata : NOP_INSTR;

    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        halted     = 1'b0;
        case (state)
            S_LOAD: begin
                load_ready = 1'b1;
                if (accept && last_word) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (trap_taken && HALT_ON_TRAP) begin
                    state_next = S_HALT;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = S_LOAD;
            end
        endcase
        if (restart) begin
            state_next = S_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_LOAD;
            wr_ptr      <= '0;
            word_count  <= '0;
            core_rst    <= 1'b1;
            fault_pc    <= '0;
            fault_cause <= '0;
            trap_count  <= '0;
        end else begin
            state    <= state_next;
            // Derived from the next state so the core leaves reset in the
            // very first RUN cycle and re-enters it the cycle after a halt.
            core_rst <= (state_next != S_RUN);
            if (restart) begin
                wr_ptr     <= '0;
                word_count <= '0;
                trap_count <= '0;
            end else begin
                if (accept) begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    word_count <= word_count + 1'b1;
                end
                if (trap_taken) begin
                    if (HALT_ON_TRAP) begin
                        fault_pc    <= pc;
                        fault_cause <= trap_cause;
                    end else begin
                        if (trap_count != 8'd255) begin
                            trap_count <= trap_count + 8'd1;
                        end
                        if (trap_count == 8'd0) begin
                            fault_pc    <= pc;
                            fault_cause <= trap_cause;
                        end
                    end
                end
            end
        end
    end

endmodule
